qspi_io_shifter: RTL and testbench

- Byte-oriented SPI/quad-SPI master shift engine.
- Serialises command/address/data bytes onto four SIO lanes and deserialises read bytes back, generating sck and cs_n.
- Sits directly upstream of the per-pin tristate stage: produces per-lane output value and output-enable, and consumes the sampled pin input.
- Used in sim benches and on hardware to talk to the flash model/emulator.

---
 rtl/qspi_io_shifter.sv | 222 ++++++++++++++++++++++
 tb/tb_qspi_io_shifter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_io_shifter.sv
// qspi_io_shifter
//    Byte-oriented SPI / quad-SPI master shift engine. Each accepted byte is
//    shifted MSB first on one lane (8 sck periods) or on four lanes
//    (2 sck periods). Read bytes are returned with a one-cycle rx_valid pulse.
//    sck is mode 0 (idle low). Lanes are sampled on the sck rising edge and
//    updated on the sck falling edge.
//
// Parameter
//    CLK_DIV   sys_clk cycles per sck half-period, 1..255
//
// Ports
//    sys_clk, sys_rst_n           clock, async active-low reset
//    tx_valid/tx_ready            byte request handshake
//    tx_data, tx_quad, tx_dir,    byte, lane mode, direction (1 = read)
//    tx_last                      and release cs_n after this byte
//    rx_valid, rx_data            received byte, one-cycle pulse
//    sck, cs_n                    SPI clock and chip select
//    sio_o, sio_oe, sio_i         per-lane value / enable / sampled pin
//    busy                         transfer engine not idle
//
// Build option
//    QSPI_SIO_TRISTATE_EN: replaces sio_o/sio_oe/sio_i with inout sio[3:0]
//    driven from the same registers; timing is unchanged.
//
// State  | meaning
// IDLE   | cs_n high, ready for the first byte of a frame
// LEAD   | cs_n low, first bit(s) on the lanes, one half-period before sck rises
// SHIFT  | sck toggling on each divider tick
// WAIT   | byte done, cs_n held low, sck low, waiting for the next byte
// TRAIL  | last byte done, one half-period with sck low before cs_n rises
// GAP    | cs_n high for at least one half-period before IDLE
module qspi_io_shifter #(
   parameter int CLK_DIV = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic [7:0] tx_data,
   input  logic       tx_quad,
   input  logic       tx_dir,
   input  logic       tx_last,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       sck,
   output logic       cs_n,
`ifdef QSPI_SIO_TRISTATE_EN
   inout  wire  [3:0] sio,
`else
   output logic [3:0] sio_o,
   output logic [3:0] sio_oe,
   input  logic [3:0] sio_i,
`endif
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEAD, S_SHIFT, S_WAIT, S_TRAIL, S_GAP
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     r_state, w_state_nxt;
   logic [7:0] r_div_cnt;
   logic       r_sck, r_cs_n, r_rx_valid;
   logic [7:0] r_rx_data, r_tx_sr, r_rx_sr;
   logic [3:0] r_sio_o, r_sio_oe, r_bit_cnt;
   logic       r_quad, r_dir, r_last;

   logic       w_active, w_tick;
   logic       w_load, w_rise, w_shift, w_byte_end, w_cs_release;
   logic [7:0] w_tx_next;
   logic [3:0] w_sio_i;

   // Single mode keeps HOLD#/WP# high and leaves lane 1 as the MISO input.
   function automatic logic [3:0] f_lane_o(input logic [7:0] b, input logic q, input logic d);
      if (q) return d ? 4'b0000 : b[7:4];
      else   return {2'b11, 1'b0, d ? 1'b0 : b[7]};
   endfunction

   function automatic logic [3:0] f_lane_oe(input logic q, input logic d);
      if (q) return d ? 4'b0000 : 4'b1111;
      else   return 4'b1101;
   endfunction

   assign w_active  = (r_state == S_LEAD) || (r_state == S_SHIFT) ||
                      (r_state == S_TRAIL) || (r_state == S_GAP);
   assign w_tick    = w_active && (r_div_cnt == DIV_LAST);
   assign w_tx_next = r_quad ? {r_tx_sr[3:0], 4'b0000} : {r_tx_sr[6:0], 1'b0};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      tx_ready     = 1'b0;
      w_load       = 1'b0;
      w_rise       = 1'b0;
      w_shift      = 1'b0;
      w_byte_end   = 1'b0;
      w_cs_release = 1'b0;
      case (r_state)
         S_IDLE, S_WAIT: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               w_load      = 1'b1;
               w_state_nxt = S_LEAD;
            end
         end
         S_LEAD: begin
            if (w_tick) begin
               w_rise      = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_tick) begin
               if (!r_sck) begin
                  w_rise = 1'b1;
               end else if (r_bit_cnt != 4'd0) begin
                  w_shift = 1'b1;
               end else begin
                  w_byte_end = 1'b1;
                  // A byte offered after the last one belongs to the next
                  // frame, so it is not taken while the frame is closing.
                  tx_ready = !r_last;
                  if (r_last) begin
                     w_state_nxt = S_TRAIL;
                  end else if (tx_valid) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_nxt = S_WAIT;
                  end
               end
            end
         end
         S_TRAIL: begin
            if (w_tick) begin
               w_cs_release = 1'b1;
               w_state_nxt  = S_GAP;
            end
         end
         S_GAP: begin
            if (w_tick) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_div_cnt  <= 8'd0;
         r_sck      <= 1'b0;
         r_cs_n     <= 1'b1;
         r_rx_valid <= 1'b0;
         r_rx_data  <= 8'h00;
         r_tx_sr    <= 8'h00;
         r_rx_sr    <= 8'h00;
         r_sio_o    <= 4'b0000;
         r_sio_oe   <= 4'b0000;
         r_bit_cnt  <= 4'd0;
         r_quad     <= 1'b0;
         r_dir      <= 1'b0;
         r_last     <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_div_cnt  <= (w_active && !w_tick) ? r_div_cnt + 8'd1 : 8'd0;
         if (w_load) begin
            r_tx_sr   <= tx_data;
            r_quad    <= tx_quad;
            r_dir     <= tx_dir;
            r_last    <= tx_last;
            r_bit_cnt <= tx_quad ? 4'd2 : 4'd8;
            r_cs_n    <= 1'b0;
            r_sio_o   <= f_lane_o(tx_data, tx_quad, tx_dir);
            r_sio_oe  <= f_lane_oe(tx_quad, tx_dir);
         end
         if (w_rise) begin
            r_sck     <= 1'b1;
            r_rx_sr   <= r_quad ? {r_rx_sr[3:0], w_sio_i} : {r_rx_sr[6:0], w_sio_i[1]};
            r_bit_cnt <= r_bit_cnt - 4'd1;
         end
         if (w_shift) begin
            r_sck   <= 1'b0;
            r_tx_sr <= w_tx_next;
            r_sio_o <= f_lane_o(w_tx_next, r_quad, r_dir);
         end
         if (w_byte_end) begin
            r_sck <= 1'b0;
            if (r_dir) begin
               r_rx_valid <= 1'b1;
               r_rx_data  <= r_rx_sr;
            end
         end
         if (w_cs_release) begin
            r_cs_n   <= 1'b1;
            r_sio_oe <= 4'b0000;
            r_sio_o  <= 4'b0000;
         end
      end
   end

   assign sck      = r_sck;
   assign cs_n     = r_cs_n;
   assign rx_valid = r_rx_valid;
   assign rx_data  = r_rx_data;
   assign busy     = (r_state != S_IDLE);

`ifdef QSPI_SIO_TRISTATE_EN
   for (genvar k = 0; k < 4; k++) begin : g_pad
      assign sio[k] = r_sio_oe[k] ? r_sio_o[k] : 1'bz;
   end
   assign w_sio_i = sio;
`else
   assign sio_o   = r_sio_o;
   assign sio_oe  = r_sio_oe;
   assign w_sio_i = sio_i;
`endif

endmodule

// File: tb/tb_qspi_io_shifter.sv
module tb_qspi_io_shifter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // CLK_DIV = 2 instance
   logic       d2_tx_valid = 1'b0, d2_tx_ready, d2_tx_quad = 1'b0, d2_tx_dir = 1'b0, d2_tx_last = 1'b0;
   logic [7:0] d2_tx_data = 8'h00, d2_rx_data;
   logic       d2_rx_valid, d2_sck, d2_cs_n, d2_busy;
   logic [3:0] d2_sio_o, d2_sio_oe, d2_sio_i = 4'b0000;

   // CLK_DIV = 1 instance
   logic       d1_tx_valid = 1'b0, d1_tx_ready, d1_tx_quad = 1'b0, d1_tx_dir = 1'b0, d1_tx_last = 1'b0;
   logic [7:0] d1_tx_data = 8'h00, d1_rx_data;
   logic       d1_rx_valid, d1_sck, d1_cs_n, d1_busy;
   logic [3:0] d1_sio_o, d1_sio_oe, d1_sio_i = 4'b0000;

   qspi_io_shifter #(.CLK_DIV(2)) u_dut2 (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .tx_valid(d2_tx_valid), .tx_ready(d2_tx_ready), .tx_data(d2_tx_data),
      .tx_quad(d2_tx_quad), .tx_dir(d2_tx_dir), .tx_last(d2_tx_last),
      .rx_valid(d2_rx_valid), .rx_data(d2_rx_data), .sck(d2_sck), .cs_n(d2_cs_n),
      .sio_o(d2_sio_o), .sio_oe(d2_sio_oe), .sio_i(d2_sio_i), .busy(d2_busy));

   qspi_io_shifter #(.CLK_DIV(1)) u_dut1 (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .tx_valid(d1_tx_valid), .tx_ready(d1_tx_ready), .tx_data(d1_tx_data),
      .tx_quad(d1_tx_quad), .tx_dir(d1_tx_dir), .tx_last(d1_tx_last),
      .rx_valid(d1_rx_valid), .rx_data(d1_rx_data), .sck(d1_sck), .cs_n(d1_cs_n),
      .sio_o(d1_sio_o), .sio_oe(d1_sio_oe), .sio_i(d1_sio_i), .busy(d1_busy));

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor / flash-slave state for the CLK_DIV = 2 instance
   int         m_rises, m_rxv, m_cs_rises, m_cs_falls, m_oe_err;
   logic [7:0] m_lane, m_rx, m_slave;
   logic [15:0] m_nib;
   logic       m_slave_quad;
   int         m_rise_cyc[$];

   task automatic mon_clear();
      m_rises = 0; m_rxv = 0; m_cs_rises = 0; m_cs_falls = 0; m_oe_err = 0;
      m_lane = 8'h00; m_rx = 8'h00; m_nib = 16'h0000;
      m_rise_cyc.delete();
   endtask

   // Present the slave bit(s) for the next sck rise.
   task automatic set_slave();
      if (m_slave_quad) d2_sio_i = (m_rises % 2 == 0) ? m_slave[7:4] : m_slave[3:0];
      else              d2_sio_i = {2'b00, m_slave[7 - (m_rises % 8)], 1'b0};
   endtask

   task automatic mon2(input int ncyc, input logic [3:0] exp_oe, input int stop_rises);
      logic p_sck, p_cs;
      p_sck = d2_sck;
      p_cs  = d2_cs_n;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (d2_sck && !p_sck) begin
            m_rises++;
            m_lane = {m_lane[6:0], d2_sio_o[0]};
            m_nib  = {m_nib[11:0], d2_sio_o};
            m_rise_cyc.push_back(c);
            set_slave();
         end
         if (d2_rx_valid) begin
            m_rxv++;
            m_rx = d2_rx_data;
         end
         if (!d2_cs_n && d2_sio_oe !== exp_oe) m_oe_err++;
         if (d2_cs_n && !p_cs) m_cs_rises++;
         if (!d2_cs_n && p_cs) m_cs_falls++;
         p_sck = d2_sck;
         p_cs  = d2_cs_n;
         if (stop_rises > 0 && m_rises == stop_rises) break;
      end
   endtask

   task automatic send2(input logic [7:0] d, input logic q, input logic dir, input logic last);
      int n;
      n = 0;
      d2_tx_valid = 1'b1; d2_tx_data = d; d2_tx_quad = q; d2_tx_dir = dir; d2_tx_last = last;
      while (d2_tx_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("handshake_bound", 32'(n < 200), 32'd1);
      @(negedge clk);
      d2_tx_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad, rxv, r1, rxc1, tog1;
      int cyc1[$];
      logic [7:0] b1, rx1;
      logic p1;

      // Reset
      repeat (3) @(negedge clk);
      check("rst_cs_n", d2_cs_n, 1'b1);
      check("rst_sck", d2_sck, 1'b0);
      check("rst_sio_oe", d2_sio_oe, 4'b0000);
      check("rst_sio_o", d2_sio_o, 4'b0000);
      check("rst_rx_valid", d2_rx_valid, 1'b0);
      check("rst_rx_data", d2_rx_data, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_ready", d2_tx_ready, 1'b1);
      check("idle_busy", d2_busy, 1'b0);

      // Single write 0xA5, last
      m_slave = 8'h00; m_slave_quad = 1'b0; mon_clear(); set_slave();
      send2(8'hA5, 1'b0, 1'b0, 1'b1);
      check("sw_cs_low_after_accept", d2_cs_n, 1'b0);
      check("sw_oe_first", d2_sio_oe, 4'b1101);
      check("sw_o_first", d2_sio_o, 4'b1101);
      check("sw_busy", d2_busy, 1'b1);
      mon2(60, 4'b1101, 0);
      check("sw_rises", m_rises, 8);
      check("sw_bits", m_lane, 8'hA5);
      check("sw_lead_len", m_rise_cyc[0], 1);
      check("sw_sck_period", m_rise_cyc[1] - m_rise_cyc[0], 4);
      check("sw_oe_hold", m_oe_err, 0);
      check("sw_no_rx", m_rxv, 0);
      check("sw_cs_release", m_cs_rises, 1);
      check("sw_end_cs_n", d2_cs_n, 1'b1);
      check("sw_end_idle", d2_busy, 1'b0);

      // Quad read, slave returns 0x3C
      m_slave = 8'h3C; m_slave_quad = 1'b1; mon_clear(); set_slave();
      send2(8'h00, 1'b1, 1'b1, 1'b1);
      check("qr_oe_first", d2_sio_oe, 4'b0000);
      mon2(40, 4'b0000, 0);
      check("qr_rises", m_rises, 2);
      check("qr_rx_pulse_len", m_rxv, 1);
      check("qr_rx_seen", m_rx, 8'h3C);
      check("qr_rx_data", d2_rx_data, 8'h3C);
      check("qr_oe_hold", m_oe_err, 0);

      // Back-to-back quad writes 0xEB, 0x12
      m_slave = 8'h00; m_slave_quad = 1'b0; mon_clear();
      fork
         mon2(80, 4'b1111, 0);
         begin
            send2(8'hEB, 1'b1, 1'b0, 1'b0);
            send2(8'h12, 1'b1, 1'b0, 1'b1);
         end
      join
      check("b2b_rises", m_rises, 4);
      check("b2b_nibbles", m_nib, 16'hEB12);
      check("b2b_no_gap", m_rise_cyc[3] - m_rise_cyc[0], 12);
      check("b2b_cs_fall", m_cs_falls, 1);
      check("b2b_cs_rise", m_cs_rises, 1);
      check("b2b_oe_hold", m_oe_err, 0);

      // Single write 0xC3 without last, 10-cycle gap, then 0x81 with last
      mon_clear(); set_slave();
      send2(8'hC3, 1'b0, 1'b0, 1'b0);
      mon2(40, 4'b1101, 0);
      check("gap_first_bits", m_lane, 8'hC3);
      check("gap_wait_sck", d2_sck, 1'b0);
      check("gap_wait_cs_n", d2_cs_n, 1'b0);
      check("gap_wait_ready", d2_tx_ready, 1'b1);
      check("gap_wait_busy", d2_busy, 1'b1);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!(d2_sck === 1'b0 && d2_cs_n === 1'b0 && d2_tx_ready === 1'b1)) bad++;
      end
      check("gap_wait_stable", bad, 0);
      mon_clear();
      send2(8'h81, 1'b0, 1'b0, 1'b1);
      check("gap_lead_cs_n", d2_cs_n, 1'b0);
      check("gap_lead_ready", d2_tx_ready, 1'b0);
      mon2(60, 4'b1101, 0);
      check("gap_lead_len", m_rise_cyc[0], 1);
      check("gap_second_bits", m_lane, 8'h81);
      check("gap_cs_release", m_cs_rises, 1);

      // Reset after three rises of a single read
      m_slave = 8'hB7; m_slave_quad = 1'b0; mon_clear(); set_slave();
      send2(8'h00, 1'b0, 1'b1, 1'b1);
      mon2(60, 4'b1101, 3);
      check("rst_mid_rises", m_rises, 3);
      check("rst_mid_sck_high", d2_sck, 1'b1);
      check("rst_mid_read_o", d2_sio_o, 4'b1100);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_cs_n", d2_cs_n, 1'b1);
      check("rst_mid_sck", d2_sck, 1'b0);
      check("rst_mid_oe", d2_sio_oe, 4'b0000);
      check("rst_mid_busy", d2_busy, 1'b0);
      rxv = 0;
      repeat (3) begin
         @(negedge clk);
         if (d2_rx_valid !== 1'b0) rxv++;
      end
      check("rst_mid_no_rx", rxv, 0);
      rst_n = 1'b1;
      @(negedge clk);
      m_slave = 8'h00; mon_clear(); set_slave();
      send2(8'h5A, 1'b0, 1'b0, 1'b1);
      mon2(60, 4'b1101, 0);
      check("post_rst_rises", m_rises, 8);
      check("post_rst_bits", m_lane, 8'h5A);
      check("post_rst_no_rx", m_rxv, 0);
      check("post_rst_cs_n", d2_cs_n, 1'b1);

      // CLK_DIV = 1 single read 0x9F
      b1 = 8'h9F;
      d1_sio_i = {2'b00, b1[7], 1'b0};
      @(negedge clk);
      check("d1_idle_ready", d1_tx_ready, 1'b1);
      d1_tx_valid = 1'b1; d1_tx_data = 8'h00; d1_tx_quad = 1'b0; d1_tx_dir = 1'b1; d1_tx_last = 1'b1;
      @(negedge clk);
      d1_tx_valid = 1'b0;
      r1 = 0; rxc1 = 0; tog1 = 0; rx1 = 8'h00;
      p1 = d1_sck;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (d1_sck !== p1) tog1++;
         if (d1_sck && !p1) begin
            r1++;
            cyc1.push_back(c);
            if (r1 < 8) d1_sio_i[1] = b1[7 - r1];
         end
         if (d1_rx_valid) begin
            rxc1++;
            rx1 = d1_rx_data;
         end
         p1 = d1_sck;
      end
      check("d1_rises", r1, 8);
      check("d1_sck_toggles", tog1, 16);
      check("d1_sck_period", cyc1[1] - cyc1[0], 2);
      check("d1_rx_pulse_len", rxc1, 1);
      check("d1_rx_data", rx1, 8'h9F);
      check("d1_end_cs_n", d1_cs_n, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
